// File: rtl/dtw_strip_sched.sv
// Strip sequencer for the 6-PE DTW systolic array: walks the cost matrix in
// strips of NPE template rows, streaming the reference as a skewed wavefront.
module dtw_strip_sched #(
    parameter int NPE    = 6,
    parameter int IW     = 5,
    parameter int MAXLEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [5:0]        len_t,
    input  logic [5:0]        len_r,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              t_rd,
    output logic [IW-1:0]     t_addr,
    output logic              r_rd,
    output logic [IW-1:0]     r_addr,
    output logic              arr_ena,
    output logic [IW-1:0]     tindex,
    output logic [IW-1:0]     rindex,
    output logic [2*NPE-1:0]  tsrc,
    output logic [2*NPE-1:0]  rsrc,
    output logic [NPE-1:0]    pe_vld,
    output logic [2:0]        strip,
    output logic [2:0]        last_pe
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] FETCH = 3'd1;
    localparam logic [2:0] RUN   = 3'd2;
    localparam logic [2:0] NEXT  = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    logic [2:0] state;
    logic [5:0] n, m, k;
    logic [2:0] s;
    logic [2:0] last_pe_q;
    logic       err_q;
    logic       legal;
    logic [5:0] nm1;
    logic [7:0] base, kk, nn, mm;
    logic       in_run;

    assign legal  = (len_t != '0) && (len_t <= 6'(MAXLEN)) &&
                    (len_r != '0) && (len_r <= 6'(MAXLEN));
    assign nm1    = len_t - 6'd1;
    assign base   = 8'(s) * 8'(NPE);
    assign kk     = 8'(k);
    assign nn     = 8'(n);
    assign mm     = 8'(m);
    assign in_run = (state == RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            n         <= '0;
            m         <= '0;
            k         <= '0;
            s         <= '0;
            last_pe_q <= '0;
            err_q     <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (legal) begin
                            n         <= len_t;
                            m         <= len_r;
                            s         <= '0;
                            last_pe_q <= 3'(nm1 % 6'(NPE));
                            state     <= FETCH;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    k     <= '0;
                    state <= RUN;
                end
                RUN: begin
                    // wavefront drains NPE-1 cycles after the last R element
                    if (kk == mm + 8'(NPE - 2)) state <= NEXT;
                    else k <= k + 6'd1;
                end
                NEXT: begin
                    if (base + 8'(NPE) < nn) begin
                        s     <= s + 3'd1;
                        state <= FETCH;
                    end else begin
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        busy    = (state != IDLE);
        done    = (state == DONE);
        err     = err_q;
        last_pe = last_pe_q;
        strip   = (state != IDLE) ? s : '0;
        arr_ena = in_run;
        t_rd    = 1'b0;
        t_addr  = '0;
        r_rd    = 1'b0;
        r_addr  = '0;
        tindex  = '0;
        rindex  = '0;
        if (state == FETCH) begin
            t_rd   = 1'b1;
            t_addr = IW'(base);
            r_rd   = 1'b1;
        end else if (in_run) begin
            if (kk + 8'd1 < mm) begin
                r_rd   = 1'b1;
                r_addr = IW'(kk + 8'd1);
            end
            if ((kk + 8'd1 < 8'(NPE)) && (base + kk + 8'd1 < nn)) begin
                t_rd   = 1'b1;
                t_addr = IW'(base + kk + 8'd1);
            end
            if ((kk < 8'(NPE)) && (base + kk < nn)) tindex = IW'(base + kk);
            if (kk < mm) rindex = IW'(kk);
        end
    end

    // PE0 sits in the MSB field of pe_vld/tsrc/rsrc
    for (genvar g = 0; g < NPE; g++) begin : g_lane
        localparam logic [7:0] GI = 8'(g);
        logic act;
        assign act = in_run && (kk >= GI) && (kk - GI < mm) && (base + GI < nn);
        assign pe_vld[NPE-1-g] = act;
        assign tsrc[2*(NPE-1-g) +: 2] = (act && (kk == GI)) ? 2'b01 : 2'b00;
        if (g == 0) begin : g_head
            assign rsrc[2*(NPE-1-g) +: 2] = act ? 2'b01 : 2'b00;
        end else begin : g_body
            assign rsrc[2*(NPE-1-g) +: 2] = act ? 2'b10 : 2'b00;
        end
    end

endmodule

// File: tb/tb_dtw_strip_sched.sv
// Bench for dtw_strip_sched: a time-indexed schedule model checked every cycle,
// plus directed scenarios with hand-computed latencies and lane patterns.
module tb_dtw_strip_sched;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [5:0]  len_t, len_r;
    logic        busy, done, err, t_rd, r_rd, arr_ena;
    logic [4:0]  t_addr, r_addr, tindex, rindex;
    logic [11:0] tsrc, rsrc;
    logic [5:0]  pe_vld;
    logic [2:0]  strip, last_pe;

    always #5 clk = ~clk;

    dtw_strip_sched #(.NPE(6), .IW(5), .MAXLEN(32)) dut (
        .clk(clk), .rst(rst), .start(start), .len_t(len_t), .len_r(len_r),
        .busy(busy), .done(done), .err(err), .t_rd(t_rd), .t_addr(t_addr),
        .r_rd(r_rd), .r_addr(r_addr), .arr_ena(arr_ena), .tindex(tindex),
        .rindex(rindex), .tsrc(tsrc), .rsrc(rsrc), .pe_vld(pe_vld),
        .strip(strip), .last_pe(last_pe)
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%0h want=%0h", name, $time, act, exp);
        end
    endtask

    // Model: a run is a timeline of S strips of M+7 cycles followed by one DONE cycle.
    bit         m_run = 0;
    bit         m_err = 0;
    int         m_t, m_n, m_m, m_total;
    int         m_lastpe = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_run = 0; m_err = 0; m_lastpe = 0;
        end else begin
            m_err = 0;
            if (m_run) begin
                m_t++;
                if (m_t > m_total) m_run = 0;
            end else if (start) begin
                if (len_t >= 1 && len_t <= 32 && len_r >= 1 && len_r <= 32) begin
                    m_run = 1; m_t = 1; m_n = int'(len_t); m_m = int'(len_r);
                    m_total  = ((m_n + 5) / 6) * (m_m + 7) + 1;
                    m_lastpe = (m_n - 1) % 6;
                end else begin
                    m_err = 1;
                end
            end
        end
    end

    int e_busy, e_done, e_err, e_trd, e_taddr, e_rrd, e_raddr, e_ena;
    int e_tidx, e_ridx, e_tsrc, e_rsrc, e_vld, e_strip;
    int c_idx, c_s, c_p, c_k, c_ns, c_base;

    always @(negedge clk) begin
        if (chk_en) begin
            e_busy = 0; e_done = 0; e_trd = 0; e_taddr = 0; e_rrd = 0; e_raddr = 0;
            e_ena = 0; e_tidx = 0; e_ridx = 0; e_tsrc = 0; e_rsrc = 0; e_vld = 0; e_strip = 0;
            e_err = m_err;
            if (m_run) begin
                e_busy = 1;
                c_idx = m_t - 1;
                c_s = c_idx / (m_m + 7);
                c_p = c_idx % (m_m + 7);
                c_ns = (m_n + 5) / 6;
                if (c_s >= c_ns) begin
                    e_done = 1; e_strip = c_ns - 1;
                end else begin
                    e_strip = c_s;
                    c_base = 6 * c_s;
                    if (c_p == 0) begin
                        e_trd = 1; e_taddr = c_base; e_rrd = 1;
                    end else if (c_p <= m_m + 5) begin
                        c_k = c_p - 1;
                        e_ena = 1;
                        if (c_k + 1 < m_m) begin e_rrd = 1; e_raddr = c_k + 1; end
                        if (c_k + 1 < 6 && c_base + c_k + 1 < m_n) begin
                            e_trd = 1; e_taddr = c_base + c_k + 1;
                        end
                        if (c_k < 6 && c_base + c_k < m_n) e_tidx = c_base + c_k;
                        if (c_k < m_m) e_ridx = c_k;
                        for (int i = 0; i < 6; i++) begin
                            if (c_k - i >= 0 && c_k - i < m_m && c_base + i < m_n) begin
                                e_vld |= 1 << (5 - i);
                                e_rsrc |= ((i == 0) ? 1 : 2) << (2 * (5 - i));
                                if (c_k == i) e_tsrc |= 1 << (2 * (5 - i));
                            end
                        end
                    end
                end
            end
            chk("busy", 32'(busy), e_busy);
            chk("done", 32'(done), e_done);
            chk("err", 32'(err), e_err);
            chk("t_rd", 32'(t_rd), e_trd);
            chk("t_addr", 32'(t_addr), e_taddr);
            chk("r_rd", 32'(r_rd), e_rrd);
            chk("r_addr", 32'(r_addr), e_raddr);
            chk("arr_ena", 32'(arr_ena), e_ena);
            chk("tindex", 32'(tindex), e_tidx);
            chk("rindex", 32'(rindex), e_ridx);
            chk("tsrc", 32'(tsrc), e_tsrc);
            chk("rsrc", 32'(rsrc), e_rsrc);
            chk("pe_vld", 32'(pe_vld), e_vld);
            chk("strip", 32'(strip), e_strip);
            chk("last_pe", 32'(last_pe), m_lastpe);
        end
    end

    logic [5:0]  vld_log [0:511];
    logic [11:0] tsrc_log[0:511];
    logic [11:0] rsrc_log[0:511];
    int          taddr_max;

    // Pulse start with (n, m); lat is the cycle index of done after the accepting edge.
    task automatic go(input int n, input int m, output int lat);
        @(negedge clk);
        start = 1'b1; len_t = 6'(n); len_r = 6'(m);
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        taddr_max = 0;
        while (1) begin
            vld_log[lat] = pe_vld; tsrc_log[lat] = tsrc; rsrc_log[lat] = rsrc;
            if (t_rd === 1'b1 && int'(t_addr) > taddr_max) taddr_max = int'(t_addr);
            if (done === 1'b1 || lat >= 500) break;
            @(negedge clk);
            lat++;
        end
    endtask

    int lat, w, cnt, d1, d2, d3, idle_gap, dcount, ab_at, abort;

    initial begin
        rst = 1'b1; start = 1'b0; len_t = '0; len_r = '0;
        repeat (2) @(negedge clk);
        chk_en = 1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_vld", 32'(pe_vld), 0);
        chk("rst_trd", 32'(t_rd), 0);
        rst = 1'b0;
        @(negedge clk);

        go(6, 6, lat);
        chk("n6m6_lat", lat, 14);
        chk("n6m6_k0", 32'(vld_log[2]), 6'b100000);
        chk("n6m6_k5", 32'(vld_log[7]), 6'b111111);
        chk("n6m6_k10", 32'(vld_log[12]), 6'b000001);
        chk("n6m6_lastpe", 32'(last_pe), 5);

        go(13, 4, lat);
        chk("n13m4_lat", lat, 34);
        chk("n13m4_s2k0", 32'(vld_log[24]), 6'b100000);
        chk("n13m4_taddr", taddr_max, 12);
        chk("n13m4_lastpe", 32'(last_pe), 0);

        go(1, 1, lat);
        chk("n1m1_lat", lat, 9);
        chk("n1m1_vld", 32'(vld_log[2]), 6'b100000);
        chk("n1m1_tsrc", 32'(tsrc_log[2]), 12'b01_0000000000);
        chk("n1m1_rsrc", 32'(rsrc_log[2]), 12'b01_0000000000);
        chk("n1m1_k1", 32'(vld_log[3]), 0);

        // illegal lengths
        @(negedge clk); start = 1'b1; len_t = 6'd0; len_r = 6'd5;
        @(negedge clk); start = 1'b0;
        chk("err0_pulse", 32'(err), 1);
        chk("err0_busy", 32'(busy), 0);
        chk("err0_rd", 32'({t_rd, r_rd}), 0);
        @(negedge clk);
        chk("err0_clear", 32'(err), 0);
        start = 1'b1; len_t = 6'd5; len_r = 6'd33;
        @(negedge clk); start = 1'b0;
        chk("err33_pulse", 32'(err), 1);
        chk("err33_busy", 32'(busy), 0);
        go(7, 3, lat);
        chk("after_err_lat", lat, 21);

        // abort at strip 1, k=3
        @(negedge clk); start = 1'b1; len_t = 6'd12; len_r = 6'd8;
        @(negedge clk); start = 1'b0;
        lat = 1;
        while (lat < 20) begin @(negedge clk); lat++; end
        chk("abort_strip", 32'(strip), 1);
        chk("abort_ena", 32'(arr_ena), 1);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_vld", 32'(pe_vld), 0);
        chk("abort_ena0", 32'(arr_ena), 0);
        chk("abort_lastpe", 32'(last_pe), 0);
        dcount = 0;
        repeat (6) begin @(negedge clk); if (done === 1'b1) dcount++; end
        chk("abort_nodone", dcount, 0);
        go(12, 8, lat);
        chk("restart_lat", lat, 31);

        // start held high: back-to-back runs
        @(negedge clk); start = 1'b1; len_t = 6'd6; len_r = 6'd2;
        cnt = 0; d1 = 0; d2 = 0; d3 = 0; idle_gap = 0;
        while (d3 == 0 && cnt < 200) begin
            @(negedge clk); cnt++;
            if (done === 1'b1) begin
                if (d1 == 0) d1 = cnt; else if (d2 == 0) d2 = cnt; else d3 = cnt;
            end
            if (d1 != 0 && d2 == 0 && busy !== 1'b1) idle_gap++;
        end
        start = 1'b0;
        chk("held_d1", d1, 10);
        chk("held_gap12", d2 - d1, 11);
        chk("held_gap23", d3 - d2, 11);
        chk("held_idle", idle_gap, 1);
        repeat (3) @(negedge clk);

        // randomized runs, occasionally illegal or aborted
        for (int it = 0; it < 30; it++) begin
            @(negedge clk);
            len_t = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 40)) : 6'($urandom_range(1, 32));
            len_r = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 40)) : 6'($urandom_range(1, 32));
            start = 1'b1;
            @(negedge clk); start = 1'b0;
            abort = ($urandom_range(0, 5) == 0) ? 1 : 0;
            ab_at = $urandom_range(1, 60);
            w = 0;
            while (busy === 1'b1 && w < 400) begin
                if (abort == 1 && w == ab_at) begin
                    rst = 1'b1; @(negedge clk); rst = 1'b0;
                end else begin
                    @(negedge clk);
                end
                w++;
            end
            chk("rand_idle", 32'(busy), 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dtw_strip_sched.md
Name: dtw_strip_sched

Overview:
- Sequencing controller for the 6-PE DTW systolic array.
- Takes a start command with template length N (T) and reference length M (R), each 1..32.
- Walks the DTW cost matrix in horizontal strips of 6 T rows. Per strip it streams R through the array as a skewed wavefront.
- Drives the array's enable, element-fetch addresses, injected indices and the per-PE 2-bit source selects. Reports which PE/column lanes carry valid cells and which PE holds the final cell.

Parameters:
NPE, 6, number of PEs in the array (bit ordering: PE0 occupies the MSB field)
IW, 5, element index width
MAXLEN, 32, maximum sequence length

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
start  in  1  begin computation; sampled only in IDLE
len_t  in  6  N, template length, legal 1..32
len_r  in  6  M, reference length, legal 1..32
busy  out  1  high from the cycle after an accepted start through the DONE state
done  out  1  one-cycle pulse at completion
err  out  1  one-cycle pulse when a start carries an illegal length
t_rd  out  1  template memory read strobe (1-cycle read latency)
t_addr  out  5  template read address
r_rd  out  1  reference memory read strobe (1-cycle read latency)
r_addr  out  5  reference read address
arr_ena  out  1  array enable
tindex  out  5  index of the T element injected this cycle
rindex  out  5  index of the R element injected this cycle
tsrc  out  12  per-PE T source; PE i uses bits [11-2i:10-2i]
rsrc  out  12  per-PE R source; same packing as tsrc
pe_vld  out  6  per-PE valid cell this cycle; PE i uses bit 5-i
strip  out  3  current strip number s, 0..5
last_pe  out  3  (N-1) mod 6, latched at start

Behaviour:
- Source encoding for tsrc and rsrc: 00 hold, 01 load external input, 10 take neighbour, 11 unused (never driven).
- Reset:
  - All outputs go to 0 and the FSM goes to IDLE.
  - rst asserted mid-operation aborts immediately; no done pulse is generated.
- FSM states: IDLE, FETCH, RUN, NEXT, DONE.
- IDLE:
  - start with N and M both in 1..32: latch N, M and last_pe, set s=0, go to FETCH.
  - start with N=0, M=0, N>32 or M>32: err=1 for one cycle, stay in IDLE.
  - start is ignored in every other state.
- FETCH (1 cycle):
  - t_rd=r_rd=1, t_addr=6s, r_addr=0.
  - Clear wavefront counter k; go to RUN.
- RUN (M+5 cycles, k = 0..M+4):
  - arr_ena=1.
  - Prefetch: r_rd=1 with r_addr=k+1 when k+1<M. t_rd=1 with t_addr=6s+k+1 when k+1<6 and 6s+k+1<N. Strobes are 0 otherwise.
  - PE i is active when 0 ≤ k-i < M and row 6s+i < N. Active sets pe_vld bit 5-i.
  - rsrc for PE0 = 01 when k<M. rsrc for PE i>0 = 10 when active.
  - tsrc for PE i = 01 at k==i when the row is valid.
  - All inactive lanes get 00.
  - tindex=6s+k while k<6 and the row is valid, else 0.
  - rindex=k while k<M, else 0.
  - At k==M+4: go to NEXT.
- NEXT (1 cycle), arr_ena=0:
  - If 6(s+1) < N: s increments, go to FETCH.
  - Else go to DONE.
- DONE (1 cycle): done=1, busy=1; next state IDLE, busy=0.
- Arithmetic and timing:
  - Number of strips S = ceil(N/6).
  - Each strip costs M+7 cycles.
  - done is asserted S·(M+7)+1 cycles after the clock edge that sampled start.
  - All counters are sized so k ≤ 36 and 6s+k never wraps.
- Partial last strip: rows ≥ N have pe_vld, tsrc and rsrc forced to 0 for the whole strip.
- start held high through completion: a new run is accepted only on the first IDLE cycle after DONE.
- start coincident with rst: rst wins.

Test Plan:
- N=6, M=6, start pulse:
  - Exactly one strip; RUN lasts 11 cycles.
  - pe_vld follows the diagonal 100000, 110000, … 111111 at k=5, then drains to 000001 at k=10.
  - done at cycle 14 after start; busy is high for 14 cycles.
- N=13, M=4:
  - Strips 0, 1, 2; strip 2 has only PE0 valid (pe_vld[5] only).
  - t_addr reaches 12; last_pe=0.
  - done at cycle 34.
- N=1, M=1:
  - RUN lasts 6 cycles, pe_vld=100000 only at k=0; tsrc=01 and rsrc=01 for PE0 at k=0.
  - done at cycle 9.
- len_t=0 or len_r=33 with start: err pulses once, busy stays 0, no memory reads; a following legal start runs normally.
- rst asserted at RUN k=3 of strip 1 (N=12, M=8): next cycle all outputs are 0, state is IDLE and no done pulse; a restart completes in 2·15+1 cycles.
- start held high continuously with N=6, M=2: runs back-to-back, each done is 10 cycles after its accepting edge, and there is exactly one IDLE cycle between runs.
